// File: rtl/ecl_ram_array.sv
// rtl/ecl_ram_array.sv - synchronous ECL-style RAM array with clear sequencer and word parity
//
// Purpose
//   WIDTH x DEPTH word RAM modelled on a bank of MC10144/10145 chips sharing
//   one address and enable set. Adds a registered read port, a post-reset
//   clear sequencer, and per-word even parity with a sticky error flag and
//   a parity-inversion hook for exercising the checker.
//
// Ports
//   clk       in   1      system clock, all state changes on posedge
//   CROBAR    in   1      synchronous active-high reset
//   a         in   AW     word address
//   d         in   WIDTH  write data
//   nen1..3   in   1      chip enables, active low, all three must be low
//   nwrite    in   1      0 = write, 1 = read (when selected)
//   inj_perr  in   1      store inverted parity on this write
//   perr_clr  in   1      clear the sticky parity error flag
//   q         out  WIDTH  registered read data, idles low
//   busy      out  1      clear sequencer running, accesses ignored
//   perr      out  1      sticky parity error

module ecl_ram_array #(
    parameter int               WIDTH          = 1,
    parameter int               DEPTH          = 256,
    parameter int               AW             = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter logic [WIDTH-1:0] INIT_VAL       = '0,
    parameter bit               CLEAR_ON_RESET = 1'b1
) (
    input  logic             clk,
    input  logic             CROBAR,
    input  logic [AW-1:0]    a,
    input  logic [WIDTH-1:0] d,
    input  logic             nen1,
    input  logic             nen2,
    input  logic             nen3,
    input  logic             nwrite,
    input  logic             inj_perr,
    input  logic             perr_clr,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             perr
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Address compare is done one bit wider so non-power-of-2 depths work.
    localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [AW-1:0]    cnt;

    // Each word carries its data plus one parity bit in the MSB.
    logic [WIDTH:0]   mem [DEPTH];

    logic             sel;
    logic             in_range;
    logic             wr_en;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH:0]   rd_word;
    logic [WIDTH-1:0] rd_data;
    logic             rd_par;
    logic             par_err;

    assign busy     = (state == ST_CLEAR);
    assign sel      = ~nen1 & ~nen2 & ~nen3;
    assign in_range = ({1'b0, a} < DEPTH_EXT);
    assign wr_en    = sel & ~nwrite & ~busy & in_range;
    assign rd_en    = sel &  nwrite & ~busy & in_range;

    // Out-of-range addresses never reach the array; the read result is
    // discarded anyway, so any in-range index is fine here.
    assign rd_addr  = in_range ? a : '0;
    assign rd_word  = mem[rd_addr];
    assign rd_data  = rd_word[WIDTH-1:0];
    assign rd_par   = rd_word[WIDTH];
    assign par_err  = rd_en & ((^rd_data) != rd_par);

    // State register
    always_ff @(posedge clk) begin
        if (CROBAR) begin
            state <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: the clear pass ends on the cycle that writes the last word.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR: begin
                if (cnt == LAST_IDX) begin
                    state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                state_nxt = ST_READY;
            end
            default: begin
                state_nxt = ST_READY;
            end
        endcase
    end

    // Clear address counter
    always_ff @(posedge clk) begin
        if (CROBAR) begin
            cnt <= '0;
        end else if (busy) begin
            cnt <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
        end
    end

    // Array write port: the sequencer owns the array while busy.
    always_ff @(posedge clk) begin
        if (!CROBAR) begin
            if (busy) begin
                mem[cnt] <= {^INIT_VAL, INIT_VAL};
            end else if (wr_en) begin
                mem[a] <= {(^d) ^ inj_perr, d};
            end
        end
    end

    // Registered read and sticky parity flag. A new error beats perr_clr.
    always_ff @(posedge clk) begin
        if (CROBAR) begin
            q    <= '0;
            perr <= 1'b0;
        end else begin
            q    <= rd_en ? rd_data : '0;
            perr <= par_err | (perr & ~perr_clr);
        end
    end

endmodule

// File: tb/tb_ecl_ram_array.sv
// tb/tb_ecl_ram_array.sv - self-checking bench for ecl_ram_array
module tb_ecl_ram_array;

    localparam int         DA     = 16;
    localparam int         DB     = 12;
    localparam logic [3:0] INIT_A = 4'hB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       crobar_a, nen1_a, nen2_a, nen3_a, nwrite_a, inj_a, pclr_a;
    logic [3:0] a_a, d_a, q_a;
    logic       busy_a, perr_a;

    logic       crobar_b, nen1_b, nen2_b, nen3_b, nwrite_b, inj_b, pclr_b;
    logic [3:0] a_b, d_b, q_b;
    logic       busy_b, perr_b;

    ecl_ram_array #(.WIDTH(4), .DEPTH(DA), .INIT_VAL(INIT_A), .CLEAR_ON_RESET(1'b1)) u_a (
        .clk(clk), .CROBAR(crobar_a), .a(a_a), .d(d_a),
        .nen1(nen1_a), .nen2(nen2_a), .nen3(nen3_a), .nwrite(nwrite_a),
        .inj_perr(inj_a), .perr_clr(pclr_a),
        .q(q_a), .busy(busy_a), .perr(perr_a)
    );

    ecl_ram_array #(.WIDTH(4), .DEPTH(DB), .INIT_VAL(4'h0), .CLEAR_ON_RESET(1'b0)) u_b (
        .clk(clk), .CROBAR(crobar_b), .a(a_b), .d(d_b),
        .nen1(nen1_b), .nen2(nen2_b), .nen3(nen3_b), .nwrite(nwrite_b),
        .inj_perr(inj_b), .perr_clr(pclr_b),
        .q(q_b), .busy(busy_b), .perr(perr_b)
    );

    int total = 0;
    int bad   = 0;

    // Reference model for u_a: word contents, a per-word "stored with bad parity" flag,
    // and the number of clear cycles still to run.
    logic [3:0] mdat [DA];
    bit         mbad [DA];
    int         clear_left;
    logic [3:0] exp_q;
    logic       exp_perr;

    logic [3:0] bref [DB];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic step_a(input string tag, input logic rst, input logic [3:0] addr,
                          input logic [3:0] data, input logic e1, input logic e2,
                          input logic e3, input logic nw, input logic inj, input logic pclr);
        logic sel;
        logic err;
        crobar_a = rst; a_a = addr; d_a = data;
        nen1_a = e1; nen2_a = e2; nen3_a = e3;
        nwrite_a = nw; inj_a = inj; pclr_a = pclr;
        @(posedge clk);
        err = 1'b0;
        sel = !e1 && !e2 && !e3;
        if (rst) begin
            clear_left = DA;
            exp_q      = 4'h0;
            exp_perr   = 1'b0;
        end else begin
            if (clear_left > 0) begin
                mdat[DA - clear_left] = INIT_A;
                mbad[DA - clear_left] = 1'b0;
                clear_left--;
                exp_q = 4'h0;
            end else if (sel && !nw) begin
                mdat[addr] = data;
                mbad[addr] = inj;
                exp_q      = 4'h0;
            end else if (sel && nw) begin
                exp_q = mdat[addr];
                err   = mbad[addr];
            end else begin
                exp_q = 4'h0;
            end
            exp_perr = err || (exp_perr && !pclr);
        end
        #1;
        chk({tag, ".q"}, 32'(q_a), 32'(exp_q));
        chk({tag, ".busy"}, 32'(busy_a), 32'(clear_left > 0));
        chk({tag, ".perr"}, 32'(perr_a), 32'(exp_perr));
    endtask

    task automatic wr_a(input string tag, input logic [3:0] addr, input logic [3:0] data,
                        input logic inj);
        step_a(tag, 1'b0, addr, data, 1'b0, 1'b0, 1'b0, 1'b0, inj, 1'b0);
    endtask

    task automatic rd_a(input string tag, input logic [3:0] addr, input logic pclr);
        step_a(tag, 1'b0, addr, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, pclr);
    endtask

    task automatic idle_a(input string tag, input logic pclr);
        step_a(tag, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, pclr);
    endtask

    task automatic rst_a(input string tag);
        step_a(tag, 1'b1, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic step_b(input logic rst, input logic sel, input logic nw,
                          input logic [3:0] addr, input logic [3:0] data);
        crobar_b = rst;
        nen1_b = !sel; nen2_b = !sel; nen3_b = !sel;
        nwrite_b = nw; a_b = addr; d_b = data;
        inj_b = 1'b0; pclr_b = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        crobar_a = 1'b1; a_a = 4'h0; d_a = 4'h0; nen1_a = 1'b1; nen2_a = 1'b1; nen3_a = 1'b1;
        nwrite_a = 1'b1; inj_a = 1'b0; pclr_a = 1'b0;
        crobar_b = 1'b1; a_b = 4'h0; d_b = 4'h0; nen1_b = 1'b1; nen2_b = 1'b1; nen3_b = 1'b1;
        nwrite_b = 1'b1; inj_b = 1'b0; pclr_b = 1'b0;
        clear_left = DA; exp_q = 4'h0; exp_perr = 1'b0;

        // Reset both arrays; u_b has no clear pass so it is ready at once.
        rst_a("t1_rst");
        chk("t6_rst_busy_b", 32'(busy_b), 32'h0);
        chk("t6_rst_q_b", 32'(q_b), 32'h0);
        chk("t6_rst_perr_b", 32'(perr_b), 32'h0);
        crobar_b = 1'b0;

        // 1: clear pass lasts exactly DEPTH cycles, then every word reads INIT_VAL.
        n = 0;
        while (busy_a === 1'b1 && n < 40) begin
            idle_a("t1_clear", 1'b0);
            n++;
        end
        chk("t1_busy_len", 32'(n), 32'(DA));
        for (int k = 0; k < DA; k++) begin
            rd_a("t1_rd", 4'(k), 1'b0);
            chk("t1_init", 32'(q_a), 32'(INIT_A));
        end

        // 2: write/read, then deselect drives q low.
        wr_a("t2_wr", 4'd5, 4'hA, 1'b0);
        rd_a("t2_rd", 4'd5, 1'b0);
        chk("t2_q", 32'(q_a), 32'hA);
        step_a("t2_desel", 1'b0, 4'd5, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t2_q_idle", 32'(q_a), 32'h0);

        // 3: injected parity error is detected and sticky until perr_clr.
        wr_a("t3_wr", 4'd3, 4'h6, 1'b1);
        rd_a("t3_rd", 4'd3, 1'b0);
        chk("t3_q", 32'(q_a), 32'h6);
        chk("t3_perr", 32'(perr_a), 32'h1);
        for (int k = 0; k < 3; k++) idle_a("t3_idle", 1'b0);
        chk("t3_perr_hold", 32'(perr_a), 32'h1);
        idle_a("t3_clr", 1'b1);
        chk("t3_perr_clr", 32'(perr_a), 32'h0);

        // 4: new error and perr_clr together, set wins.
        rd_a("t4_rd_clr", 4'd3, 1'b1);
        chk("t4_set_wins", 32'(perr_a), 32'h1);
        idle_a("t4_clr", 1'b1);

        // 5: reset mid-clear at cnt=7 restarts the full pass; busy writes are dropped.
        wr_a("t5_pre_wr", 4'd12, 4'h1, 1'b0);
        rst_a("t5_rst0");
        for (int k = 0; k < 7; k++) idle_a("t5_part", 1'b0);
        rst_a("t5_rst1");
        wr_a("t5_busy_wr", 4'd2, 4'h0, 1'b0);
        n = 1;
        while (busy_a === 1'b1 && n < 40) begin
            idle_a("t5_clear", 1'b0);
            n++;
        end
        chk("t5_busy_len", 32'(n), 32'(DA));
        rd_a("t5_rd2", 4'd2, 1'b0);
        chk("t5_drop", 32'(q_a), 32'(INIT_A));
        rd_a("t5_rd12", 4'd12, 1'b0);
        chk("t5_rewrite", 32'(q_a), 32'(INIT_A));

        // Randomised traffic against the model, including occasional resets.
        for (int i = 0; i < 500; i++) begin
            step_a("rnd",
                   $urandom_range(0, 99) == 0,
                   4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)),
                   $urandom_range(0, 7) == 0,
                   $urandom_range(0, 7) == 0,
                   $urandom_range(0, 7) == 0,
                   1'($urandom_range(0, 1)),
                   $urandom_range(0, 7) == 0,
                   $urandom_range(0, 9) == 0);
        end

        // 6: DEPTH=12, no clear on reset: contents survive reset, out-of-range is inert.
        for (int k = 0; k < DB; k++) begin
            bref[k] = 4'((k * 5 + 3) & 15);
            step_b(1'b0, 1'b1, 1'b0, 4'(k), bref[k]);
        end
        step_b(1'b1, 1'b0, 1'b1, 4'h0, 4'h0);
        chk("t6_busy_after_rst", 32'(busy_b), 32'h0);
        chk("t6_q_after_rst", 32'(q_b), 32'h0);
        for (int k = 0; k < DB; k++) begin
            step_b(1'b0, 1'b1, 1'b1, 4'(k), 4'h0);
            chk("t6_retain", 32'(q_b), 32'(bref[k]));
            chk("t6_retain_perr", 32'(perr_b), 32'h0);
        end
        step_b(1'b0, 1'b1, 1'b0, 4'd13, 4'hF);
        chk("t6_oor_wr_q", 32'(q_b), 32'h0);
        for (int k = DB; k < 16; k++) begin
            step_b(1'b0, 1'b1, 1'b1, 4'(k), 4'h0);
            chk("t6_oor_q", 32'(q_b), 32'h0);
            chk("t6_oor_perr", 32'(perr_b), 32'h0);
        end
        for (int k = 0; k < DB; k++) begin
            step_b(1'b0, 1'b1, 1'b1, 4'(k), 4'h0);
            chk("t6_no_corrupt", 32'(q_b), 32'(bref[k]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
